// File: rtl/led_matrix_spi_sequencer.sv
// MAX7219 8x8 matrix init/refresh sequencer driving a 16-bit SPI master's register port.
// Optional `LED_SEQ_DIRTY_EN`: per-row dirty bits, so frames carry only rows written since their last send.
module led_matrix_spi_sequencer #(
  parameter int unsigned REFRESH_DIV    = 500000,
  parameter logic [3:0]  INTENSITY_INIT = 4'h8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        fb_we,
  input  logic [2:0]  fb_addr,
  input  logic [7:0]  fb_wdata,
  input  logic [3:0]  intensity,
  output logic        spi_select,
  output logic [2:0]  mem_addr,
  output logic        write_n,
  output logic        read_n,
  output logic [15:0] spi_wdata,
  input  logic [15:0] spi_rdata,
  input  logic        dataavailable,
  input  logic        readyfordata,
  output logic        init_done,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned      CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WR1, WR2, WAIT_RX, RD1, RD2, NEXT
  } state_t;

  state_t           state, state_next;
  logic [7:0]       fb [8];
  logic [7:0]       row_mask;
  logic [2:0]       word_idx;
  logic [2:0]       row;
  logic             send_int;
  logic             pending;
  logic             tick;
  logic             start_frame;
  logic             last_word;
  logic             need_int;
  logic             is_int_word;
  logic [3:0]       last_int;
  logic [3:0]       first_hit;
  logic [3:0]       next_hit;
  logic [15:0]      cur_word;
  logic [CNT_W-1:0] tick_cnt;
  logic             unused_rdata;

  // The read only exists to clear RRDY; the returned data has no meaning here.
  assign unused_rdata = ^spi_rdata;

  // Lowest row index >= from whose mask bit is set; bit 3 flags a hit.
  function automatic logic [3:0] find_row(input logic [7:0] mask, input logic [3:0] from);
    find_row = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) find_row = {1'b1, 3'(i)};
    end
  endfunction

  assign tick = (tick_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CNT_W'(1);
  end

  // NOTE: the row store is reset on purpose, so the first frame after init shows a blank matrix.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) fb[i] <= '0;
    end else if (fb_we) begin
      fb[fb_addr] <= fb_wdata;
    end
  end

`ifdef LED_SEQ_DIRTY_EN
  logic [7:0] dirty;

  // A host write in the same cycle as the row's LOAD keeps the row dirty for the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dirty <= 8'hFF;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (fb_we && (fb_addr == 3'(i)))
          dirty[i] <= 1'b1;
        else if ((state == LOAD) && init_done && !send_int && (row == 3'(i)))
          dirty[i] <= 1'b0;
      end
    end
  end

  assign row_mask = dirty;
`else
  assign row_mask = 8'hFF;
`endif

  always_comb begin
    first_hit   = find_row(row_mask, 4'd0);
    next_hit    = find_row(row_mask, {1'b0, row} + 4'd1);
    need_int    = (intensity != last_int);
    is_int_word = init_done ? send_int : (word_idx == 3'd3);
    cur_word    = 16'h0000;
    last_word   = 1'b0;
    if (!init_done) begin
      case (word_idx)
        3'd0:    cur_word = 16'h0C01;
        3'd1:    cur_word = 16'h0B07;
        3'd2:    cur_word = 16'h0900;
        3'd3:    cur_word = {12'h0A0, intensity};
        default: cur_word = 16'h0F00;
      endcase
      last_word = (word_idx == 3'd4);
    end else if (send_int) begin
      cur_word  = {12'h0A0, intensity};
      last_word = !first_hit[3];
    end else begin
      cur_word  = {4'h0, {1'b0, row} + 4'd1, fb[row]};
      last_word = !next_hit[3];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every output and next-state value is defaulted first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    spi_select  = 1'b0;
    write_n     = 1'b1;
    read_n      = 1'b1;
    mem_addr    = 3'd0;
    frame_done  = 1'b0;
    busy        = (state != IDLE);
    start_frame = 1'b0;
    case (state)
      IDLE: begin
        if (!init_done) begin
          state_next = LOAD;
        end else if (enable && (tick || pending) && (need_int || first_hit[3])) begin
          state_next  = LOAD;
          start_frame = 1'b1;
        end
      end
      LOAD:    if (readyfordata) state_next = WR1;
      WR1, WR2: begin
        spi_select = 1'b1;
        write_n    = 1'b0;
        mem_addr   = 3'd1;
        state_next = (state == WR1) ? WR2 : WAIT_RX;
      end
      WAIT_RX: if (dataavailable) state_next = RD1;
      RD1, RD2: begin
        spi_select = 1'b1;
        read_n     = 1'b0;
        state_next = (state == RD1) ? RD2 : NEXT;
      end
      NEXT: begin
        if (last_word) begin
          // busy drops here so it falls together with frame_done.
          state_next = IDLE;
          busy       = 1'b0;
          frame_done = init_done;
        end else begin
          state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_idx  <= 3'd0;
      row       <= 3'd0;
      send_int  <= 1'b0;
      init_done <= 1'b0;
      last_int  <= INTENSITY_INIT;
      spi_wdata <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start_frame) begin
            send_int <= need_int;
            row      <= first_hit[2:0];
          end
        end
        LOAD: begin
          spi_wdata <= cur_word;
          if (is_int_word) last_int <= intensity;
        end
        NEXT: begin
          if (!init_done) begin
            word_idx <= word_idx + 3'd1;
            if (word_idx == 3'd4) init_done <= 1'b1;
          end else if (send_int) begin
            send_int <= 1'b0;
            row      <= first_hit[2:0];
          end else begin
            row <= next_hit[2:0];
          end
        end
        default: ;
      endcase
    end
  end

  // A tick while busy is remembered once; IDLE either consumes it or drops it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   pending <= 1'b0;
    else if (!enable || (state == IDLE && init_done)) pending <= 1'b0;
    else if (tick)                                  pending <= 1'b1;
  end

endmodule

// File: tb/tb_led_matrix_spi_sequencer.sv
// Bench for led_matrix_spi_sequencer: SPI master model, word-queue reference model, protocol monitor.
// Also builds with LED_SEQ_DIRTY_EN defined, where the model sends only dirty rows.
module tb_led_matrix_spi_sequencer;

  localparam int DIV = 300;
`ifdef LED_SEQ_DIRTY_EN
  localparam bit DIRTY_MODE = 1'b1;
`else
  localparam bit DIRTY_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        fb_we = 1'b0;
  logic [2:0]  fb_addr = 3'd0;
  logic [7:0]  fb_wdata = 8'd0;
  logic [3:0]  intensity = 4'h8;
  logic        spi_select, write_n, read_n;
  logic [2:0]  mem_addr;
  logic [15:0] spi_wdata;
  logic [15:0] spi_rdata;
  logic        dataavailable, readyfordata;
  logic        init_done, frame_done, busy;

  always #5 clk = ~clk;

  led_matrix_spi_sequencer #(.REFRESH_DIV(DIV), .INTENSITY_INIT(4'h8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .intensity(intensity), .spi_select(spi_select), .mem_addr(mem_addr),
    .write_n(write_n), .read_n(read_n), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .dataavailable(dataavailable), .readyfordata(readyfordata), .init_done(init_done),
    .frame_done(frame_done), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the matrix should receive, as a queue of command words.
  logic [7:0]  m_fb [8];
  logic [7:0]  m_dirty;
  logic [3:0]  m_last_int;
  logic [15:0] exp_q [$];
  logic [15:0] act_log [$];

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_fb[r] = 8'h00;
    m_dirty = 8'hFF;
  endtask

  task automatic expect_init();
    exp_q.push_back(16'h0C01);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h0900);
    exp_q.push_back({12'h0A0, intensity});
    exp_q.push_back(16'h0F00);
    m_last_int = intensity;
  endtask

  task automatic expect_frame(output int n);
    n = 0;
    if (intensity != m_last_int) begin
      exp_q.push_back({12'h0A0, intensity});
      m_last_int = intensity;
      n++;
    end
    for (int r = 0; r < 8; r++) begin
      if (!DIRTY_MODE || m_dirty[r]) begin
        exp_q.push_back({4'h0, 4'(r + 1), m_fb[r]});
        m_dirty[r] = 1'b0;
        n++;
      end
    end
  endtask

  // SPI master model plus per-cycle protocol and word checking.
  int  wr_run = 0, rd_run = 0, wr_count = 0, frames = 0, words_since_rst = 0;
  int  rx_cnt = -1, rx_delay = 20;
  bit  rfd_low = 1'b0;
  logic prev_rfd = 1'b1, prev_da = 1'b0, prev_init = 1'b0;

  initial begin
    readyfordata  = 1'b1;
    dataavailable = 1'b0;
    spi_rdata     = 16'hA5A5;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        wr_run = 0; rd_run = 0; rx_cnt = -1; dataavailable = 1'b0;
        words_since_rst = 0; prev_init = 1'b0;
      end else begin
        check("port_decode", {spi_select, mem_addr}, {(!write_n || !read_n), (!write_n ? 3'd1 : 3'd0)});
        check("rw_exclusive", write_n | read_n, 1);
        if (!write_n) begin
          wr_run++;
          if (wr_run == 1) begin
            check("write_after_trdy", prev_rfd, 1);
            act_log.push_back(spi_wdata);
            wr_count++;
            words_since_rst++;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_write: got 0x%04h, no word expected (t=%0t)", spi_wdata, $time);
            end else begin
              check("word", spi_wdata, exp_q.pop_front());
            end
            rx_cnt = rx_delay;
          end
        end else begin
          if (wr_run != 0) check("write_len", wr_run, 2);
          wr_run = 0;
        end
        if (!read_n) begin
          rd_run++;
          if (rd_run == 1) begin
            check("read_after_rrdy", prev_da, 1);
            dataavailable = 1'b0;
          end
        end else begin
          if (rd_run != 0) check("read_len", rd_run, 2);
          rd_run = 0;
        end
        if (frame_done) begin
          frames++;
          check("busy_low_at_frame_done", busy, 0);
        end
        if (init_done && !prev_init) check("words_before_init_done", words_since_rst, 5);
        prev_init = init_done;
        if (wr_run != 1 && rx_cnt > 0) rx_cnt--;
        if (rx_cnt == 0) begin
          dataavailable = 1'b1;
          rx_cnt = -1;
        end
      end
      readyfordata = !rfd_low;
      prev_rfd     = readyfordata;
      prev_da      = dataavailable;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fb_write(input int r, input logic [7:0] d);
    step();
    fb_we = 1'b1; fb_addr = 3'(r); fb_wdata = d;
    step();
    fb_we = 1'b0;
    m_fb[r] = d;
    m_dirty[r] = 1'b1;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 600) begin step(); n++; end
    check(name, init_done, 1);
  endtask

  task automatic wait_frames(input string name, input int count, input int budget);
    int f0 = frames;
    int n = 0;
    while ((frames - f0) < count && n < budget) begin step(); n++; end
    check(name, frames - f0, count);
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n = 0;
    while (!busy && n < budget) begin step(); n++; end
    check(name, busy, 1);
  endtask

  // Sends one frame with enable pulsed around it, or confirms silence if the model expects none.
  task automatic run_frame(input string name, output int n, output int base);
    int f0, w0;
    expect_frame(n);
    base = act_log.size();
    f0 = frames; w0 = wr_count;
    enable = 1'b1;
    if (n > 0) begin
      wait_frames(name, 1, 1500);
    end else begin
      repeat (650) step();
      check({name, "_no_frame"}, frames - f0, 0);
      check({name, "_no_write"}, wr_count - w0, 0);
    end
    enable = 1'b0;
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_word_count"}, act_log.size() - base, n);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] init_lit [5];
    logic [7:0]  pat [8];
    int n, base, f0, w0, k, idx;
    init_lit = '{16'h0C01, 16'h0B07, 16'h0900, 16'h0A08, 16'h0F00};
    pat      = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h81, 8'h42, 8'h24, 8'h18};
    model_reset();
    m_last_int = 4'h8;

    // Reset state and the init sequence.
    step(); step();
    check("rst_ctrl", {spi_select, write_n, read_n, mem_addr, init_done, frame_done, busy}, 9'b0_1_1_000_000);
    check("rst_wdata", spi_wdata, 16'h0000);
    expect_init();
    reset_n = 1'b1;
    wait_init("init_done");
    for (int i = 0; i < 5; i++) check($sformatf("init_word%0d", i), act_log[i], init_lit[i]);
    check("init_queue_empty", exp_q.size(), 0);
    step();
    check("idle_after_init", busy, 0);

    // First frame from a known pattern.
    for (int r = 0; r < 8; r++) fb_write(r, pat[r]);
    run_frame("frame_pattern", n, base);
    check("frame_row0", act_log[base], 16'h0181);
    check("frame_row7", act_log[base + 7], 16'h0818);

    // Intensity 8 -> 3 puts 0x0A03 first; unchanged intensity sends no 0x0Axx.
    intensity = 4'h3;
    run_frame("frame_int_change", n, base);
    check("int_word_first", act_log[base], 16'h0A03);
    fb_write(2, 8'h3C);
    fb_write(6, 8'hE7);
    run_frame("frame_int_same", n, base);
    k = 0;
    for (int i = base; i < act_log.size(); i++) if (act_log[i][15:8] == 8'h0A) k++;
    check("no_int_word", k, 0);

    // TRDY held low in LOAD, slow RRDY, enable dropped mid-frame.
    for (int r = 0; r < 8; r++) fb_write(r, 8'(r * 17 + 5));
    expect_frame(n);
    rfd_low = 1'b1;
    enable = 1'b1;
    wait_busy("stall_frame_start", 400);
    enable = 1'b0;
    w0 = wr_count;
    repeat (50) step();
    check("no_write_while_trdy_low", wr_count - w0, 0);
    rx_delay = 60;
    rfd_low = 1'b0;
    wait_frames("stall_frame_done", 1, 1500);
    check("stall_queue_empty", exp_q.size(), 0);
    f0 = frames;
    repeat (400) step();
    check("idle_after_disable", frames - f0, 0);

    // Ticks during a long frame yield exactly one extra frame.
    for (int r = 0; r < 8; r++) fb_write(r, ~8'(r));
    expect_frame(n);
    rx_delay = 80;
    w0 = wr_count;
    enable = 1'b1;
    k = 0;
    while ((wr_count - w0) < 8 && k < 1500) begin step(); k++; end
    check("long_frame_rows", wr_count - w0, 8);
    fb_write(0, 8'h5A);
    expect_frame(n);
    wait_frames("long_frame_done", 1, 400);
    wait_busy("pending_frame_start", 4);
    enable = 1'b0;
    wait_frames("pending_frame_done", 1, 1500);
    f0 = frames;
    repeat (700) step();
    check("no_third_frame", frames - f0, 0);
    check("pending_queue_empty", exp_q.size(), 0);
    rx_delay = 20;

    // Reset in the middle of WAIT_RX, then init re-runs and the buffer reads back cleared.
    for (int r = 0; r < 8; r++) fb_write(r, 8'hF0 | 8'(r));
    expect_frame(n);
    w0 = wr_count;
    enable = 1'b1;
    k = 0;
    while (wr_count == w0 && k < 400) begin step(); k++; end
    check("reset_test_write_seen", wr_count - w0, 1);
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    check("midrst_ctrl", {spi_select, write_n, read_n, mem_addr, init_done, frame_done, busy}, 9'b0_1_1_000_000);
    check("midrst_wdata", spi_wdata, 16'h0000);
    enable = 1'b0;
    exp_q.delete();
    model_reset();
    step(); step();
    expect_init();
    base = act_log.size();
    reset_n = 1'b1;
    wait_init("reinit_done");
    check("reinit_queue_empty", exp_q.size(), 0);
    check("reinit_int_word", act_log[base + 3], 16'h0A03);
    run_frame("frame_after_reset", n, base);
    check("cleared_row0", act_log[base], 16'h0100);

    // Single row write, then a tick with no writes.
    fb_write(5, 8'hC3);
    run_frame("frame_row5", n, base);
    idx = DIRTY_MODE ? 0 : 5;
    check("row5_word", act_log[base + idx], 16'h06C3);
    run_frame("frame_no_writes", n, base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
